// File: rtl/conv_linebuf_ctrl_pkg.sv
// Shared definitions for the convolution line-buffer controller: state
// encoding and the supported kernel-size range.
package conv_ctrl_pkg;

    localparam int K_MIN = 2;
    localparam int K_MAX = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/conv_linebuf_ctrl_if.sv
// Job/config, pixel-stream and line-FIFO control signals of the line-buffer
// controller. The master side issues jobs and pixels; the slave is the controller.
interface conv_linebuf_ctrl_if #(
    parameter int ROW_W    = 5,
    parameter int STRIDE_W = 3
);
    logic                start;
    logic [ROW_W-1:0]    row_len;
    logic [ROW_W-1:0]    num_rows;
    logic [STRIDE_W-1:0] stride;
    logic                in_valid;
    logic                empty;
    logic                ff_rst;
    logic                ff_wen;
    logic                ff_ren;
    logic [ROW_W-1:0]    ff_row_len;
    logic                win_valid;
    logic [ROW_W-1:0]    out_col;
    logic [ROW_W-1:0]    out_row;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output start, row_len, num_rows, stride, in_valid, empty,
        input  ff_rst, ff_wen, ff_ren, ff_row_len, win_valid,
               out_col, out_row, busy, done, err
    );

    modport slave (
        input  start, row_len, num_rows, stride, in_valid, empty,
        output ff_rst, ff_wen, ff_ren, ff_row_len, win_valid,
               out_col, out_row, busy, done, err
    );
endinterface

// File: rtl/conv_linebuf_ctrl_stride_phase_cnt.sv
// Stride-phase down-counter: zero marks positions that land on the stride grid,
// so window alignment is found without a divider.
module stride_phase_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] stride,
    output logic         zero
);
    logic [W-1:0] phase;

    assign zero = (phase == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase <= '0;
        end else if (load) begin
            phase <= '0;
        end else if (step) begin
            phase <= zero ? (stride - W'(1)) : (phase - W'(1));
        end
    end
endmodule

// File: rtl/conv_linebuf_ctrl.sv
// Line-buffer sequencer for a KxK convolution window: validates the job, fills
// K-1 rows plus K-1 pixels, streams windows on the stride grid, then drains.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; config checked and latched on accept
// FILL   | writing FIFO until (K-1)*row_len+(K-1) beats are buffered
// STREAM | write + read per beat, windows reported, underflow flagged
// DRAIN  | frame complete, read out FIFO until empty, then done
module conv_linebuf_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int K        = 3,
    parameter int ROW_W    = 5,
    parameter int STRIDE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    conv_linebuf_ctrl_if.slave  bus
);
    localparam int FW = ROW_W + 3;
    localparam logic [ROW_W-1:0]    K_R   = ROW_W'(K);
    localparam logic [ROW_W-1:0]    KM1_R = ROW_W'(K - 1);
    localparam logic [STRIDE_W-1:0] K_S   = STRIDE_W'(K);
    localparam logic [FW-1:0]       KM1_F = FW'(K - 1);

    if (K < K_MIN || K > K_MAX) begin : g_k_range
        $error("conv_linebuf_ctrl: K outside supported range");
    end

    state_t              state;
    logic [ROW_W-1:0]    row_len_q, num_rows_q;
    logic [STRIDE_W-1:0] stride_q;
    logic [ROW_W-1:0]    col, row;
    logic [ROW_W-1:0]    win_col_cnt, win_row_cnt;
    logic [FW-1:0]       fill_cnt, fill_thr;
    logic                ff_rst_q, win_valid_q, done_q, err_q;
    logic [ROW_W-1:0]    out_col_q, out_row_q;

    logic cfg_bad, job_start, accept;
    logic col_last, row_last, col_ge, row_ge;
    logic col_zero, row_zero, win_hit;

    assign cfg_bad   = (bus.stride == '0) || (bus.stride > K_S) ||
                       (bus.row_len < K_R) || (bus.num_rows < K_R);
    assign job_start = (state == ST_IDLE) && bus.start && !cfg_bad;
    assign accept    = ((state == ST_FILL) || (state == ST_STREAM)) && bus.in_valid;

    assign col_last = (col == row_len_q - ROW_W'(1));
    assign row_last = (row == num_rows_q - ROW_W'(1));
    assign col_ge   = (col >= KM1_R);
    assign row_ge   = (row >= KM1_R);
    assign win_hit  = accept && col_ge && row_ge && col_zero && row_zero;

    assign bus.ff_wen     = accept;
    assign bus.ff_ren     = (state == ST_STREAM) ? (bus.in_valid & ~bus.empty) :
                            (state == ST_DRAIN)  ? ~bus.empty : 1'b0;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.ff_row_len = row_len_q;
    assign bus.ff_rst     = ff_rst_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.out_col    = out_col_q;
    assign bus.out_row    = out_row_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

    // Column phase restarts at every row wrap so col=K-1 is always on-grid.
    stride_phase_cnt #(.W(STRIDE_W)) u_col_phase (
        .clk    (clk),
        .rst    (rst),
        .load   (job_start | (accept & col_last)),
        .step   (accept & col_ge & ~col_last),
        .stride (stride_q),
        .zero   (col_zero)
    );

    stride_phase_cnt #(.W(STRIDE_W)) u_row_phase (
        .clk    (clk),
        .rst    (rst),
        .load   (job_start),
        .step   (accept & col_last & row_ge),
        .stride (stride_q),
        .zero   (row_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            row_len_q   <= '0;
            num_rows_q  <= '0;
            stride_q    <= '0;
            col         <= '0;
            row         <= '0;
            win_col_cnt <= '0;
            win_row_cnt <= '0;
            fill_cnt    <= '0;
            fill_thr    <= '0;
            ff_rst_q    <= 1'b0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_col_q   <= '0;
            out_row_q   <= '0;
        end else begin
            ff_rst_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            win_valid_q <= win_hit;

            if (win_hit) begin
                out_col_q   <= win_col_cnt;
                out_row_q   <= win_row_cnt;
                win_col_cnt <= win_col_cnt + ROW_W'(1);
            end

            // A row wrap overrides the window-column increment above.
            if (accept) begin
                if (col_last) begin
                    col         <= '0;
                    row         <= row + ROW_W'(1);
                    win_col_cnt <= '0;
                    if (row_ge && row_zero) win_row_cnt <= win_row_cnt + ROW_W'(1);
                end else begin
                    col <= col + ROW_W'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (cfg_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            row_len_q   <= bus.row_len;
                            num_rows_q  <= bus.num_rows;
                            stride_q    <= bus.stride;
                            fill_thr    <= FW'(bus.row_len) * KM1_F + KM1_F;
                            fill_cnt    <= '0;
                            col         <= '0;
                            row         <= '0;
                            win_col_cnt <= '0;
                            win_row_cnt <= '0;
                            ff_rst_q    <= 1'b1;
                            state       <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        fill_cnt <= fill_cnt + FW'(1);
                        if (col_last && row_last)
                            state <= ST_DRAIN;
                        else if (fill_cnt + FW'(1) == fill_thr)
                            state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        if (bus.empty) err_q <= 1'b1;
                        if (col_last && row_last) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.empty) begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
